// File: rtl/div_ctrl_pkg.sv
// Shared constants and types for the EX-stage divider sequencer.
// Keeps the historic define.v names available as package localparams.
package div_ctrl_pkg;

    localparam int REG_W        = 32;
    localparam int REG_DOUBLE_W = 64;
    localparam int TIMER_W      = 6;

    localparam logic [REG_W-1:0] ZERO_WORD  = '0;
    localparam logic             DIV_START  = 1'b1;
    localparam logic             DIV_STOP   = 1'b0;
    localparam logic             RST_ENABLE = 1'b1;

    // Watchdog limit in RUN cycles; must exceed the divider's 35-cycle worst case.
    localparam int DIV_CTRL_TIMEOUT = 40;

    typedef enum logic {
        DIV_CTRL_IDLE = 1'b0,
        DIV_CTRL_RUN  = 1'b1
    } div_ctrl_state_e;

endpackage

// File: rtl/div_ctrl.sv
// Sequencer for the iterative divider: latches operands, drives start/annul,
// stalls EX until the result arrives, then emits a one-cycle HI/LO write.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DIV_CTRL_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_div_req_i,
    input  logic                    ex_signed_i,
    input  logic [REG_W-1:0]        ex_opdata1_i,
    input  logic [REG_W-1:0]        ex_opdata2_i,
    input  logic                    flush_i,
    input  logic [REG_DOUBLE_W-1:0] div_result_i,
    input  logic                    div_ready_i,
    output logic                    div_start_o,
    output logic                    div_annul_o,
    output logic                    div_signed_o,
    output logic [REG_W-1:0]        div_opdata1_o,
    output logic [REG_W-1:0]        div_opdata2_o,
    output logic                    stallreq_o,
    output logic                    whilo_o,
    output logic [REG_W-1:0]        hi_o,
    output logic [REG_W-1:0]        lo_o,
    output logic                    err_o
);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    div_ctrl_state_e    state, next_state;
    logic [TIMER_W-1:0] timer;
    logic               load;
    logic               finish;
    logic               abort;

    // NOTE: every output of this block is given a default before the case so
    // that no path leaves a signal unassigned and infers a latch.
    always_comb begin
        next_state  = state;
        load        = 1'b0;
        finish      = 1'b0;
        abort       = 1'b0;
        stallreq_o  = 1'b0;
        div_annul_o = 1'b0;
        whilo_o     = 1'b0;
        hi_o        = ZERO_WORD;
        lo_o        = ZERO_WORD;

        case (state)
            DIV_CTRL_IDLE: begin
                // Stale div_ready_i from the previous operation is ignored here.
                if (ex_div_req_i && !flush_i) begin
                    stallreq_o = 1'b1;
                    load       = 1'b1;
                    next_state = DIV_CTRL_RUN;
                end
            end
            DIV_CTRL_RUN: begin
                if (flush_i) begin
                    div_annul_o = 1'b1;
                    finish      = 1'b1;
                    next_state  = DIV_CTRL_IDLE;
                end else if (timer == TIMER_LAST) begin
                    div_annul_o = 1'b1;
                    abort       = 1'b1;
                    finish      = 1'b1;
                    next_state  = DIV_CTRL_IDLE;
                end else if (div_ready_i) begin
                    whilo_o    = 1'b1;
                    hi_o       = div_result_i[REG_DOUBLE_W-1:REG_W];
                    lo_o       = div_result_i[REG_W-1:0];
                    finish     = 1'b1;
                    next_state = DIV_CTRL_IDLE;
                end else begin
                    stallreq_o = 1'b1;
                end
            end
            default: next_state = DIV_CTRL_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    // NOTE: the operand registers are reset too, since the divider shares rst
    // and must see zeroed operands after a mid-operation reset.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state         <= DIV_CTRL_IDLE;
            timer         <= '0;
            div_start_o   <= DIV_STOP;
            div_signed_o  <= 1'b0;
            div_opdata1_o <= ZERO_WORD;
            div_opdata2_o <= ZERO_WORD;
            err_o         <= 1'b0;
        end else begin
            state <= next_state;
            err_o <= abort;
            if (load) begin
                div_opdata1_o <= ex_opdata1_i;
                div_opdata2_o <= ex_opdata2_i;
                div_signed_o  <= ex_signed_i;
                div_start_o   <= DIV_START;
                timer         <= '0;
            end else if (finish) begin
                // Dropping start for at least one edge lets the divider leave DivEnd.
                div_start_o <= DIV_STOP;
            end else if (state == DIV_CTRL_RUN && timer != '1) begin
                timer <= timer + TIMER_W'(1);
            end
        end
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencer for the iterative divider in the EX stage. It accepts a DIV/DIVU request from EX and latches the operands. It drives the divider's start/annul handshake, holds the pipeline stalled until the quotient and remainder arrive, and returns them as a one-cycle HI/LO write. It also cancels the operation on a pipeline flush and recovers from a hung divider through a watchdog.

## Interface
- `TIMEOUT`, 40: maximum cycles in RUN before abort (must exceed divider worst-case latency, 35).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset (`Rst_Enable`).
- `ex_div_req_i`  in  1  EX holds a DIV/DIVU instruction.
- `ex_signed_i`  in  1  1 = DIV, 0 = DIVU.
- `ex_opdata1_i`  in  32  dividend.
- `ex_opdata2_i`  in  32  divisor.
- `flush_i`  in  1  pipeline flush (exception/eret); kills the in-flight division.
- `div_result_i`  in  64  divider result, {remainder, quotient}.
- `div_ready_i`  in  1  divider result valid.
- `div_start_o`  out  1  registered; `DivStart`/`DivStop` to the divider.
- `div_annul_o`  out  1  combinational cancel to the divider.
- `div_signed_o`  out  1  registered copy of `ex_signed_i`.
- `div_opdata1_o`, `div_opdata2_o`  out  32 each  registered operands, stable for the whole operation.
- `stallreq_o`  out  1  combinational stall request to the pipeline controller.
- `whilo_o`  out  1  one-cycle HI/LO write enable.
- `hi_o`, `lo_o`  out  32 each  remainder and quotient; valid only when `whilo_o` = 1, otherwise 0.
- `err_o`  out  1  registered one-cycle pulse on watchdog abort.

## Operation
- The FSM has two states, IDLE and RUN, encoded `DivCtrlIdle`/`DivCtrlRun`.
- IDLE:
  - If `ex_div_req_i` = 1 and `flush_i` = 0: set `stallreq_o` = 1 in the same cycle. At the edge, latch the operands and `ex_signed_i`, set `div_start_o` to 1, clear the timer, and go to RUN.
  - Otherwise: no stall, and `div_start_o` stays 0.
  - `div_ready_i` is ignored in IDLE; the divider may still report a stale ready for one cycle.
- RUN, evaluated in priority order:
  1. `flush_i` = 1: `div_annul_o` = 1 this cycle, `stallreq_o` = 0, `whilo_o` = 0. At the edge, `div_start_o` goes to 0 and the FSM goes to IDLE.
  2. Timer = `TIMEOUT`-1: `div_annul_o` = 1 and `stallreq_o` = 0. At the edge, `err_o` pulses, `div_start_o` goes to 0, and the FSM goes to IDLE.
  3. `div_ready_i` = 1:
     - `whilo_o` = 1, `hi_o` = `div_result_i`[63:32], `lo_o` = `div_result_i`[31:0], all combinational.
     - `stallreq_o` = 0.
     - At the edge, `div_start_o` goes to 0 and the FSM goes to IDLE.
  4. Otherwise: `stallreq_o` = 1, timer increments, and `div_start_o` and the operands are held.
- A new `ex_div_req_i` while in RUN is the same instruction and is ignored.
- A zero divisor is not special-cased: the divider returns 0/0 with ready, and the controller writes HI = LO = 0.
- The controller performs no sign handling; the divider owns the two's-complement correction and requires `div_opdata1_o` to stay stable until ready.

## Timing
- Reset values:
  - state IDLE, timer 0.
  - `div_start_o`, `div_signed_o`, `err_o` = 0; operand registers = 0.
  - Combinational outputs evaluate to 0 in IDLE when there is no request.
- Reset mid-operation returns to IDLE with no `whilo_o`. The divider shares `rst` and resets in the same edge.
- Latency: the request cycle stalls. `div_start_o` rises at the next edge, and `whilo_o` coincides with the first `div_ready_i` seen in RUN. Stall therefore spans (request cycle … cycle before ready), so the EX instruction advances on the ready cycle.
- `div_start_o` is low for at least one edge between operations, so the divider always passes DivEnd → DivFree. Back-to-back divides are accepted in the first IDLE cycle after RUN.
- `flush_i` together with `div_ready_i`: flush wins, and there is no HI/LO write.
- `flush_i` together with a new request in IDLE: the request is dropped, with no stall and no start.
- The timer is 6 bits and saturates; `TIMEOUT` must be ≤ 63.

## Structure
- Shared package / `define.v`:
  - existing `Reg`, `Reg_Double`, `Zero_Word`, `DivStart`, `DivStop`, `Rst_Enable`.
  - new `DivCtrlIdle`, `DivCtrlRun`, and `DivCtrlTimeout` (default 40).
- Single flat module; no sub-module is warranted. The watchdog is an inline counter.
- The top level instantiates `div_ctrl` beside `div` and wires `stallreq_o` into the stall controller and `whilo_o`/`hi_o`/`lo_o` into the HI/LO write mux.

## Test plan
- DIVU 100 / 7 with the real divider → exactly one `whilo_o` pulse, `hi_o` = 2, `lo_o` = 14; stall is released in the same cycle.
- DIV 0xFFFFFFF9 (−7) / 2 → `lo_o` = 0xFFFFFFFD, `hi_o` = 0xFFFFFFFF.
- DIVU 5 / 0 → `whilo_o` = 1 with `hi_o` = `lo_o` = 0; `err_o` stays 0.
- Signed 0x80000000 / 3, `flush_i` pulsed 10 cycles after start:
  - `div_annul_o` = 1 for that cycle, no `whilo_o`, `stallreq_o` drops the same cycle.
  - An immediately following DIVU 9 / 3 → `lo_o` = 3, `hi_o` = 0.
- Two back-to-back DIVU, 0xFFFFFFFF / 0x10 then 12 / 5:
  - results `lo_o` = 0x0FFFFFFF, `hi_o` = 0xF, then `lo_o` = 2, `hi_o` = 2.
  - `div_start_o` is low for exactly one cycle between them.
- Stub divider that never asserts ready → `err_o` pulses at RUN cycle 40, `div_annul_o` = 1 in that cycle, stall released. A reset asserted at RUN cycle 5 of a separate run → all outputs return to reset values on the next edge.
